// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
// Shares one SPI register-access controller between two requesters
// (A = UART command path, B = on-chip requester). Round-robin grant on
// contention, one-cycle start pulse toward the controller, then waits for the
// completion pulse or a timeout and reports back to the granted port.
// Every output is driven straight from a register.

module spi_txn_arbiter #(
    parameter int SPI_ADDR_WIDTH = 6,
    parameter int SPI_DATA_WIDTH = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      i_clk_sys,
    input  logic                      i_rst,
    input  logic                      i_req_a,
    input  logic                      i_rw_a,
    input  logic [SPI_ADDR_WIDTH-1:0] i_addr_a,
    input  logic [SPI_DATA_WIDTH-1:0] i_wdata_a,
    input  logic                      i_req_b,
    input  logic                      i_rw_b,
    input  logic [SPI_ADDR_WIDTH-1:0] i_addr_b,
    input  logic [SPI_DATA_WIDTH-1:0] i_wdata_b,
    output logic                      o_ack_a,
    output logic                      o_done_a,
    output logic                      o_err_a,
    output logic [SPI_DATA_WIDTH-1:0] o_rdata_a,
    output logic                      o_ack_b,
    output logic                      o_done_b,
    output logic                      o_err_b,
    output logic [SPI_DATA_WIDTH-1:0] o_rdata_b,
    output logic                      o_spi_start,
    output logic                      o_spi_rw,
    output logic [SPI_ADDR_WIDTH-1:0] o_spi_addr,
    output logic [SPI_DATA_WIDTH-1:0] o_spi_data,
    input  logic                      i_spi_data_valid,
    input  logic [SPI_DATA_WIDTH-1:0] i_spi_data,
    output logic                      o_busy
);

    // The WAIT counter only has to reach TIMEOUT_CYCLES-1, where it stops.
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Requester fields gathered into index-able vectors; index 0 = A, 1 = B.
    logic [1:0]                     req;
    logic [1:0]                     rw;
    logic [1:0][SPI_ADDR_WIDTH-1:0] addr;
    logic [1:0][SPI_DATA_WIDTH-1:0] wdata;

    assign req   = {i_req_b, i_req_a};
    assign rw    = {i_rw_b, i_rw_a};
    assign addr  = {i_addr_b, i_addr_a};
    assign wdata = {i_wdata_b, i_wdata_a};

    state_t                    state_reg, state_next;
    logic                      last_grant_reg, last_grant_next;   // port granted most recently
    logic                      owner_reg, owner_next;             // port owning the current transaction
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic                      spi_start_reg, spi_start_next;
    logic                      spi_rw_reg, spi_rw_next;
    logic [SPI_ADDR_WIDTH-1:0] spi_addr_reg, spi_addr_next;
    logic [SPI_DATA_WIDTH-1:0] spi_data_reg, spi_data_next;
    logic                      busy_reg;

    // Decodes shared with the per-port output registers.
    logic grant;        // a request is accepted this cycle
    logic winner;       // port that wins arbitration
    logic finish;       // transaction completes this cycle
    logic timeout_hit;  // completion is due to timeout

    // State and shared output registers.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            cnt_reg        <= '0;
            spi_start_reg  <= 1'b0;
            spi_rw_reg     <= 1'b0;
            spi_addr_reg   <= '0;
            spi_data_reg   <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            cnt_reg        <= cnt_next;
            spi_start_reg  <= spi_start_next;
            spi_rw_reg     <= spi_rw_next;
            spi_addr_reg   <= spi_addr_next;
            spi_data_reg   <= spi_data_next;
            busy_reg       <= (state_next != IDLE);
        end
    end

    // Next-state logic: arbitration in IDLE, start in ISSUE, completion/timeout in WAIT.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        cnt_next        = cnt_reg;
        spi_start_next  = 1'b0;
        spi_rw_next     = spi_rw_reg;
        spi_addr_next   = spi_addr_reg;
        spi_data_next   = spi_data_reg;
        grant           = 1'b0;
        finish          = 1'b0;
        timeout_hit     = 1'b0;
        // A lone request wins outright; on contention the port not granted last wins.
        winner          = (req[0] && req[1]) ? ~last_grant_reg : req[1];

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    grant           = 1'b1;
                    owner_next      = winner;
                    last_grant_next = winner;
                    spi_rw_next     = rw[winner];
                    spi_addr_next   = addr[winner];
                    spi_data_next   = wdata[winner];
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                spi_start_next = 1'b1;
                cnt_next       = '0;
                state_next     = WAIT;
            end
            WAIT: begin
                // A completion on the terminal cycle still counts as success.
                if (i_spi_data_valid) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    finish      = 1'b1;
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-port response registers: ack, done, err and the read-data holding register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic PORT = 1'(gi);

        logic                      ack_reg;
        logic                      done_reg;
        logic                      err_reg;
        logic [SPI_DATA_WIDTH-1:0] rdata_reg;

        // Pulses are one cycle wide; rdata only moves on a successful read.
        always_ff @(posedge i_clk_sys) begin
            if (i_rst) begin
                ack_reg   <= 1'b0;
                done_reg  <= 1'b0;
                err_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                ack_reg  <= grant && (winner == PORT);
                done_reg <= finish && (owner_reg == PORT);
                err_reg  <= finish && timeout_hit && (owner_reg == PORT);
                if (finish && !timeout_hit && spi_rw_reg && (owner_reg == PORT)) begin
                    rdata_reg <= i_spi_data;
                end
            end
        end
    end

    assign o_ack_a     = g_port[0].ack_reg;
    assign o_done_a    = g_port[0].done_reg;
    assign o_err_a     = g_port[0].err_reg;
    assign o_rdata_a   = g_port[0].rdata_reg;
    assign o_ack_b     = g_port[1].ack_reg;
    assign o_done_b    = g_port[1].done_reg;
    assign o_err_b     = g_port[1].err_reg;
    assign o_rdata_b   = g_port[1].rdata_reg;
    assign o_spi_start = spi_start_reg;
    assign o_spi_rw    = spi_rw_reg;
    assign o_spi_addr  = spi_addr_reg;
    assign o_spi_data  = spi_data_reg;
    assign o_busy      = busy_reg;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: stimulus pushes expected grants and
// completions, a responder plays the SPI controller, a monitor checks.
module tb_spi_txn_arbiter;

    localparam int AW  = 6;
    localparam int DW  = 20;
    localparam int TMO = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, rw_a = 1'b0, req_b = 1'b0, rw_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          ack_a, done_a, err_a, ack_b, done_b, err_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          spi_start, spi_rw, busy;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_wdata;
    logic          spi_valid;
    logic [DW-1:0] spi_rdata;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk_sys(clk), .i_rst(rst),
        .i_req_a(req_a), .i_rw_a(rw_a), .i_addr_a(addr_a), .i_wdata_a(wdata_a),
        .i_req_b(req_b), .i_rw_b(rw_b), .i_addr_b(addr_b), .i_wdata_b(wdata_b),
        .o_ack_a(ack_a), .o_done_a(done_a), .o_err_a(err_a), .o_rdata_a(rdata_a),
        .o_ack_b(ack_b), .o_done_b(done_b), .o_err_b(err_b), .o_rdata_b(rdata_b),
        .o_spi_start(spi_start), .o_spi_rw(spi_rw), .o_spi_addr(spi_addr),
        .o_spi_data(spi_wdata), .i_spi_data_valid(spi_valid), .i_spi_data(spi_rdata),
        .o_busy(busy)
    );

    typedef struct { int port; bit rw; logic [AW-1:0] addr; logic [DW-1:0] data; } ack_exp_t;
    typedef struct { int port; bit err; logic [DW-1:0] ra; logic [DW-1:0] rb; int lat; } done_exp_t;
    typedef struct { int delay; logic [DW-1:0] data; } plan_t;

    ack_exp_t  ack_q[$];
    done_exp_t done_q[$];
    plan_t     plan_q[$];

    // Reference model state
    int            last_grant_m = 1;
    logic [DW-1:0] shadow_a = '0, shadow_b = '0;

    int    n_checks = 0, n_fails = 0;          // written by monitor only
    int    ack_seen = 0, done_seen = 0, seen_timeouts = 0, mark_used = 0, cyc = 0;
    int    stim_timeouts = 0, mark_id = 0, req_mark = 0, stray_req = 0;
    string to_name = "";
    bit    all_done = 1'b0, stray_on_ack_en = 1'b0;
    int    stray_done = 0;

    function automatic int pick_winner(bit ra, bit rb);
        if (ra && rb) return (last_grant_m == 0) ? 1 : 0;
        return rb ? 1 : 0;
    endfunction

    // Push the expected grant/completion for port p given the controller's behaviour.
    task automatic expect_txn(input int p, input int d, input logic [DW-1:0] rd, input bit with_done);
        ack_exp_t a; done_exp_t e; plan_t pl;
        a.port = p;
        a.rw   = (p == 0) ? rw_a : rw_b;
        a.addr = (p == 0) ? addr_a : addr_b;
        a.data = (p == 0) ? wdata_a : wdata_b;
        ack_q.push_back(a);
        pl.delay = d; pl.data = rd;
        plan_q.push_back(pl);
        last_grant_m = p;
        if (with_done) begin
            e.err = (d >= TMO);
            e.lat = e.err ? TMO : d + 1;
            if (!e.err && a.rw) begin
                if (p == 0) shadow_a = rd; else shadow_b = rd;
            end
            e.port = p; e.ra = shadow_a; e.rb = shadow_b;
            done_q.push_back(e);
        end
    endtask

    task automatic wait_acks(input int target, input string what);
        int n = 0;
        while (ack_seen < target && n < 200) begin @(posedge clk); n++; end
        if (ack_seen < target) begin to_name = what; stim_timeouts++; end
        @(negedge clk);
    endtask

    task automatic wait_dones(input int target, input string what);
        int n = 0;
        while (done_seen < target && n < 4 * TMO + 200) begin @(posedge clk); n++; end
        if (done_seen < target) begin to_name = what; stim_timeouts++; end
        @(negedge clk);
    endtask

    task automatic mark_req();
        req_mark = cyc + 1;
        mark_id++;
    endtask

    task automatic single(input int p, input bit rw, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd, input int d, input logic [DW-1:0] rd);
        int abase, dbase;
        @(negedge clk);
        abase = ack_seen; dbase = done_seen;
        if (p == 0) begin rw_a = rw; addr_a = ad; wdata_a = wd; end
        else        begin rw_b = rw; addr_b = ad; wdata_b = wd; end
        expect_txn(p, d, rd, 1'b1);
        if (p == 0) req_a = 1'b1; else req_b = 1'b1;
        mark_req();
        wait_acks(abase + 1, "single_ack");
        req_a = 1'b0; req_b = 1'b0;
        wait_dones(dbase + 1, "single_done");
    endtask

    // Both requests held high for n back-to-back transactions.
    task automatic both_held(input int n);
        int abase, dbase;
        abase = ack_seen; dbase = done_seen;
        for (int i = 0; i < n; i++) expect_txn(pick_winner(1'b1, 1'b1), $urandom_range(0, 10), DW'($urandom()), 1'b1);
        req_a = 1'b1; req_b = 1'b1;
        mark_req();
        wait_acks(abase + n, "held_ack");
        req_a = 1'b0; req_b = 1'b0;
        wait_dones(dbase + n, "held_done");
    endtask

    // SPI controller stand-in: completes each started transaction after its planned delay.
    initial begin
        int cd; plan_t pl; logic [DW-1:0] pdata;
        spi_valid = 1'b0; spi_rdata = '0; cd = -1; pdata = '0;
        forever begin
            @(negedge clk);
            spi_valid = 1'b0;
            if (spi_start && plan_q.size() > 0) begin
                pl = plan_q.pop_front();
                cd = (pl.delay <= TMO + 2) ? pl.delay : -1;
                pdata = pl.data;
            end
            if (cd == 0) begin spi_valid = 1'b1; spi_rdata = pdata; cd = -1; end
            else if (cd > 0) cd--;
            if ((ack_a || ack_b) && stray_on_ack_en) begin spi_valid = 1'b1; spi_rdata = DW'($urandom()); end
            if (stray_req != stray_done) begin spi_valid = 1'b1; spi_rdata = DW'($urandom()); stray_done++; end
        end
    end

    task automatic chk(input bit ok, input string name, input string act, input string want);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s: actual %s, required %s", name, act, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents ack/start/done.
    initial begin
        ack_exp_t ea; done_exp_t ed; int p, ack_cyc, start_cyc; bit e, rst_s;
        ack_cyc = 0; start_cyc = 0;
        forever begin
            @(posedge clk); rst_s = rst;
            @(negedge clk); #1; cyc++;
            if (rst_s) begin
                chk({ack_a, ack_b, done_a, done_b, err_a, err_b, spi_start, busy, spi_rw} == 9'd0
                    && rdata_a == '0 && rdata_b == '0 && spi_addr == '0 && spi_wdata == '0, "reset_state",
                    $sformatf("ctl=%b ra=%h rb=%h addr=%h data=%h", {ack_a, ack_b, done_a, done_b, err_a, err_b, spi_start, busy, spi_rw},
                              rdata_a, rdata_b, spi_addr, spi_wdata), "all zero");
            end else begin
                if (ack_a || ack_b) begin
                    p = ack_b ? 1 : 0;
                    if (ack_q.size() == 0) chk(1'b0, "unexpected_ack", $sformatf("ack port %0d", p), "no ack");
                    else begin
                        ea = ack_q.pop_front();
                        chk(!(ack_a && ack_b) && p == ea.port && spi_rw == ea.rw && spi_addr == ea.addr && spi_wdata == ea.data,
                            "ack_grant", $sformatf("ab=%b%b rw=%b addr=%h data=%h", ack_a, ack_b, spi_rw, spi_addr, spi_wdata),
                            $sformatf("port=%0d rw=%b addr=%h data=%h", ea.port, ea.rw, ea.addr, ea.data));
                    end
                    if (mark_id != mark_used) begin
                        chk(cyc == req_mark + 1, "ack_latency", $sformatf("cycle %0d", cyc), $sformatf("cycle %0d", req_mark + 1));
                        mark_used = mark_id;
                    end
                    ack_cyc = cyc;
                    ack_seen++;
                end
                if (spi_start) begin
                    chk(cyc == ack_cyc + 1 && busy, "start_timing", $sformatf("cycle %0d busy=%b", cyc, busy),
                        $sformatf("cycle %0d busy=1", ack_cyc + 1));
                    start_cyc = cyc;
                end
                if (done_a || done_b) begin
                    p = done_b ? 1 : 0;
                    e = p ? err_b : err_a;
                    if (done_q.size() == 0) chk(1'b0, "unexpected_done", $sformatf("done port %0d", p), "no done");
                    else begin
                        ed = done_q.pop_front();
                        chk(!(done_a && done_b) && p == ed.port && e == ed.err && rdata_a == ed.ra && rdata_b == ed.rb && !busy,
                            "done_result", $sformatf("port=%0d err=%b ra=%h rb=%h busy=%b", p, e, rdata_a, rdata_b, busy),
                            $sformatf("port=%0d err=%b ra=%h rb=%h busy=0", ed.port, ed.err, ed.ra, ed.rb));
                        chk(cyc - start_cyc == ed.lat, "done_latency", $sformatf("%0d cycles", cyc - start_cyc),
                            $sformatf("%0d cycles", ed.lat));
                    end
                    $display("txn %0d: port %s err=%b rdata_a=%h rdata_b=%h", done_seen, p ? "B" : "A", e, rdata_a, rdata_b);
                    done_seen++;
                end
                if ((err_a && !done_a) || (err_b && !done_b))
                    chk(1'b0, "err_without_done", $sformatf("err=%b%b done=%b%b", err_a, err_b, done_a, done_b), "err only with done");
            end
            if (stim_timeouts != seen_timeouts) begin
                chk(1'b0, {"wait_", to_name}, "no DUT event in budget", "event");
                seen_timeouts++;
            end
            if (all_done || cyc > 30000) begin
                chk(!all_done == 1'b0 && ack_q.size() == 0 && done_q.size() == 0, "queues_drained",
                    $sformatf("ack_q=%0d done_q=%0d", ack_q.size(), done_q.size()), "both empty, no watchdog");
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin
        int abase;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed: A read at 0x15, B write of all-ones at 0x3F
        single(0, 1'b1, 6'h15, 20'h00000, 40, 20'hABCDE);
        single(1, 1'b0, 6'h3F, 20'hFFFFF, 7, 20'h13579);

        // Contention: A, B, A, B
        rw_a = 1'b1; addr_a = 6'h01; wdata_a = 20'h11111;
        rw_b = 1'b1; addr_b = 6'h02; wdata_b = 20'h22222;
        both_held(4);

        // Timeout boundaries: no valid, valid on terminal cycle, valid one cycle late
        single(0, 1'b1, 6'h0A, 20'h0, 1000, 20'h55555);
        single(0, 1'b1, 6'h0B, 20'h0, TMO - 1, 20'h5A5A5);
        single(0, 1'b1, 6'h0C, 20'h0, TMO, 20'hC3C3C);

        // Spurious valid in IDLE, then during ISSUE
        stray_req++;
        repeat (4) @(negedge clk);
        stray_on_ack_en = 1'b1;
        single(1, 1'b1, 6'h21, 20'h0, 5, 20'h0BEEF);
        stray_on_ack_en = 1'b0;

        // Reset in the middle of WAIT
        @(negedge clk);
        abase = ack_seen;
        rw_a = 1'b1; addr_a = 6'h2A;
        expect_txn(0, 1000, 20'h0, 1'b0);
        req_a = 1'b1;
        mark_req();
        wait_acks(abase + 1, "rst_ack");
        req_a = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        shadow_a = '0; shadow_b = '0; last_grant_m = 1;
        repeat (5) @(negedge clk);
        stray_req++;
        repeat (3) @(negedge clk);
        both_held(2);

        // Randomized single-port traffic
        for (int i = 0; i < 12; i++) begin
            single($urandom_range(0, 1), 1'($urandom()), AW'($urandom()), DW'($urandom()),
                   $urandom_range(0, TMO + 2), DW'($urandom()));
        end

        repeat (5) @(negedge clk);
        all_done = 1'b1;
    end

endmodule
